mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mau_pkg.sv | 38 +++
 rtl/mau_lane.sv | 35 +++
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - op/state encodings and decode helpers for mem_access_unit
package mau_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  function automatic logic is_store(op_e o);
    return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
  endfunction

  // Sub-word stores need a read-modify-write through the merge buffer.
  function automatic logic is_rmw(op_e o);
    return (o == OP_SH) || (o == OP_SB);
  endfunction

  function automatic logic is_misaligned(op_e o, logic [1:0] lo);
    case (o)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane.sv
// rtl/mau_lane.sv - little-endian lane extract/extend for loads and lane merge for SB/SH
module mau_lane
  import mau_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [15:0] wdata_lo,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte   = word[{lane, 3'b000} +: 8];
    sel_half   = lane[1] ? word[31:16] : word[15:0];
    load_data  = word;
    merge_word = word;
    case (op)
      OP_LH:  load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU: load_data = {16'h0000, sel_half};
      OP_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: load_data = {24'h000000, sel_byte};
      OP_SH: begin
        if (lane[1]) merge_word[31:16] = wdata_lo;
        else         merge_word[15:0]  = wdata_lo;
      end
      OP_SB:  merge_word[{lane, 3'b000} +: 8] = wdata_lo[7:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit FSM; MAU_ALIGN_CHECK_EN enables misalignment errors
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [11:0] off_q;
  logic [11:0] off_in;
  logic [31:0] wdata_q, merge_q, rdata_q;
  logic        ack_q, err_q;
  logic        accept, mis;
  logic [31:0] load_data, merge_word;

  // Only the low 12 bits survive the 4 KiB wrap, so subtract in that width.
  assign off_in = addr[11:0] - BASE_ADDR[11:0];

`ifdef MAU_ALIGN_CHECK_EN
  assign mis = is_misaligned(op_q, off_q[1:0]);
`else
  assign mis = 1'b0;
`endif

  mau_lane u_lane (
    .op         (op_q),
    .lane       (off_q[1:0]),
    .word       (dm_dout),
    .wdata_lo   (wdata_q[15:0]),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    accept  = 1'b0;
    dm_we   = 1'b0;
    dm_din  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        ready  = 1'b1;
        accept = req;
        if (req) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        dm_we   = (op_q == OP_SW) && !mis;
        state_d = (is_rmw(op_q) && !mis) ? ST_WRITE : ST_IDLE;
      end
      ST_WRITE: begin
        dm_we   = 1'b1;
        dm_din  = merge_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) dm_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
      op_q    <= OP_LW;
      off_q   <= '0;
      wdata_q <= '0;
    end else begin
      ack_q <= ((state_q == ST_ACCESS) && (state_d == ST_IDLE)) || (state_q == ST_WRITE);
      err_q <= (state_q == ST_ACCESS) && mis;
      if (accept) begin
        op_q    <= op_e'(op);
        off_q   <= off_in;
        wdata_q <= wdata;
      end
      if ((state_q == ST_ACCESS) && !mis) begin
        if (!is_store(op_q)) rdata_q <= load_data;
        if (is_rmw(op_q))    merge_q <= merge_word;
      end
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign dm_addr = off_q[11:2];

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req;
  logic [2:0]  op;
  logic [31:0] addr, wdata, rdata, dm_din, dm_dout;
  logic        ready, ack, err, dm_we;
  logic [9:0]  dm_addr;

  logic [31:0] mem [0:1023];
  logic        clr, pl_we;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          ack_cyc;
  } exp_t;

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sbq[$];
  int   weq[$];
  vec_t vt[17];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready), .ack(ack), .rdata(rdata), .err(err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 1024; i++) mem[i] <= '0;
    else if (dm_we) mem[dm_addr] <= dm_din;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match the oldest expectation, every write its slot.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack) begin
        if (sbq.size() == 0) chk("ack_unexpected", {31'd0, ack}, 32'd0);
        else begin
          exp_t x;
          x = sbq.pop_front();
          chk("ack_cycle", cyc, x.ack_cyc);
          chk("rdata", rdata, x.rdata);
          chk("err", {31'd0, err}, {31'd0, x.err});
        end
      end
      if (dm_we) begin
        if (weq.size() == 0) chk("we_unexpected", {31'd0, dm_we}, 32'd0);
        else chk("we_cycle", cyc, weq.pop_front());
      end
    end
  end

  task automatic issue(input op_e o, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] r, input logic e);
    bit got;
    int lat;
    got   = 0;
    req   = 1'b1;
    op    = o;
    addr  = a;
    wdata = w;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ready) begin
        got      = 1;
        last_acc = cyc;
        lat      = ((o == OP_SB || o == OP_SH) && !e) ? 3 : 2;
        sbq.push_back('{rdata: r, err: e, ack_cyc: cyc + lat});
        if (!e && o == OP_SW) weq.push_back(cyc + 1);
        if (!e && (o == OP_SB || o == OP_SH)) weq.push_back(cyc + 2);
      end
      @(posedge clk); #1;
    end
    if (!got) chk("accept_timeout", {31'd0, ready}, 32'd1);
    req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sbq.size() != 0; k++) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    chk("we_drain", weq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    vt[0]  = '{OP_SW,  32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vt[1]  = '{OP_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{OP_SW,  32'h10, 32'h11223344, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{OP_SB,  32'h12, 32'h000000AB, 32'hDEADBEEF, 1'b0};
    vt[4]  = '{OP_LW,  32'h10, 32'h0,        32'h11AB3344, 1'b0};
    vt[5]  = '{OP_SW,  32'h10, 32'h8000FF80, 32'h11AB3344, 1'b0};
    vt[6]  = '{OP_LB,  32'h10, 32'h0,        32'hFFFFFF80, 1'b0};
    vt[7]  = '{OP_LBU, 32'h10, 32'h0,        32'h00000080, 1'b0};
    vt[8]  = '{OP_LH,  32'h12, 32'h0,        32'hFFFF8000, 1'b0};
    vt[9]  = '{OP_LHU, 32'h12, 32'h0,        32'h00008000, 1'b0};
    vt[10] = '{OP_SH,  32'h16, 32'h1234BEEF, 32'h00008000, 1'b0};
    vt[11] = '{OP_LW,  32'h14, 32'h0,        32'hBEEF0000, 1'b0};
    vt[12] = '{OP_LB,  32'h17, 32'h0,        32'hFFFFFFBE, 1'b0};
`ifdef MAU_ALIGN_CHECK_EN
    vt[13] = '{OP_LW,  32'h1001, 32'h0,      32'hFFFFFFBE, 1'b1};
    vt[14] = '{OP_SW,  32'h203, 32'h00000055, 32'hFFFFFFBE, 1'b1};
    vt[15] = '{OP_LHU, 32'h3,  32'h0,        32'hFFFFFFBE, 1'b1};
    vt[16] = '{OP_LW,  32'h200, 32'h0,       32'h00000000, 1'b0};
`else
    vt[13] = '{OP_LW,  32'h1001, 32'h0,      32'hCAFEF00D, 1'b0};
    vt[14] = '{OP_SW,  32'h203, 32'h00000055, 32'hCAFEF00D, 1'b0};
    vt[15] = '{OP_LHU, 32'h3,  32'h0,        32'h0000CAFE, 1'b0};
    vt[16] = '{OP_LW,  32'h200, 32'h0,       32'h00000055, 1'b0};
`endif

    reset = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;
    clr = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    @(posedge clk); #1;
    clr = 1'b0; pl_we = 1'b1; pl_addr = 10'd0; pl_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    pl_addr = 10'd8; pl_data = 32'h12345678;
    @(posedge clk); #1;
    pl_we = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_ack",   {31'd0, ack},   32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_we",    {31'd0, dm_we}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) issue(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err);
    issue(OP_LBU, 32'h15, 32'h0, 32'h00000000, 1'b0);

    // Held request: LW must be taken in the very cycle the SH acks.
    issue(OP_SH, 32'h30, 32'hFFFFA5A5, 32'h00000000, 1'b0);
    acc1 = last_acc;
    issue(OP_LW, 32'h30, 32'h0, 32'h0000A5A5, 1'b0);
    chk("b2b_accept", last_acc, acc1 + 3);
    drain();

    chk("mem_w4",  mem[4],  32'h8000FF80);
    chk("mem_w5",  mem[5],  32'hBEEF0000);
    chk("mem_w0",  mem[0],  32'hCAFEF00D);
    chk("mem_w12", mem[12], 32'h0000A5A5);
`ifdef MAU_ALIGN_CHECK_EN
    chk("mem_w128", mem[128], 32'h00000000);
`else
    chk("mem_w128", mem[128], 32'h00000055);
`endif

    // Reset lands in the WRITE cycle of an SH: no write, no ack.
    req = 1'b1; op = OP_SH; addr = 32'h20; wdata = 32'h0000FFFF;
    @(negedge clk);
    chk("r38_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("r38_we_gated", {31'd0, dm_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("r38_ready_after", {31'd0, ready}, 32'd1);
    chk("r38_no_ack", {31'd0, ack}, 32'd0);
    chk("r38_rdata", rdata, 32'd0);
    @(negedge clk);
    chk("r38_no_ack2", {31'd0, ack}, 32'd0);
    chk("r38_mem_w8", mem[8], 32'h12345678);
    chk("r38_sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
